// File: rtl/str_det_pkg.sv
// Shared types and helpers for the string-detector family.
// Optional build macro used by this family: STR_DET_MASK_EN (per-bit compare mask).
package str_det_pkg;

  // Frame sequencer states: counting bits, or flushing between frames.
  typedef enum logic [0:0] {
    RUN = 1'b0,
    GAP = 1'b1
  } state_e;

  localparam int DEF_PAT_W     = 4;
  localparam int DEF_FRAME_LEN = 20;
  localparam int DEF_GAP_LEN   = 4;

  // Increment a counter of the given width, sticking at its all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (count >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = count + 32'd1;
    end
  endfunction

endpackage

// File: rtl/str_det_frame_if.sv
// Control / result bundle between the serial front end, the frame detector
// and the result collector. pat_mask exists only when STR_DET_MASK_EN is defined.
interface str_det_frame_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 5
);
  logic [PAT_W-1:0] pattern;
`ifdef STR_DET_MASK_EN
  logic [PAT_W-1:0] pat_mask;
`endif
  logic             mode;
  logic             clear;
  logic             bit_in;
  logic             bit_valid;
  logic             match;
  logic [CNT_W-1:0] live_count;
  logic [CNT_W-1:0] result;
  logic             frame_done;
  logic             busy_gap;

`ifdef STR_DET_MASK_EN
  modport master (output pattern, pat_mask, mode, clear, bit_in, bit_valid,
                  input  match, live_count, result, frame_done, busy_gap);
  modport slave  (input  pattern, pat_mask, mode, clear, bit_in, bit_valid,
                  output match, live_count, result, frame_done, busy_gap);
`else
  modport master (output pattern, mode, clear, bit_in, bit_valid,
                  input  match, live_count, result, frame_done, busy_gap);
  modport slave  (input  pattern, mode, clear, bit_in, bit_valid,
                  output match, live_count, result, frame_done, busy_gap);
`endif
endinterface

// File: rtl/str_det_cmp.sv
// Combinational window/pattern comparator shared by the detector variants.
// With STR_DET_MASK_EN defined, mask bits at 0 are don't-care.
module str_det_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] window_i,
  input  logic [W-1:0] pattern_i,
`ifdef STR_DET_MASK_EN
  input  logic [W-1:0] mask_i,
`endif
  output logic         hit_o
);

  // Hit when every compared bit of the window equals the pattern.
  always_comb begin
`ifdef STR_DET_MASK_EN
    hit_o = (((window_i ^ pattern_i) & mask_i) == {W{1'b0}});
`else
    hit_o = (window_i == pattern_i);
`endif
  end

endmodule

// File: rtl/str_det_frame.sv
// Framed serial pattern counter: counts PAT_W-bit pattern hits over frames of
// FRAME_LEN accepted bits, publishes the per-frame count, then flushes for
// GAP_LEN cycles. Optional build macro: STR_DET_MASK_EN (adds pat_mask).
module str_det_frame
  import str_det_pkg::*;
#(
  parameter int PAT_W     = DEF_PAT_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input logic            clk,
  input logic            rst_n,
  str_det_frame_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CNT_W-1:0] FILL_THR = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  // Only the PAT_W-1 most recent bits are stored; the incoming bit completes the window.
  state_e           state_q;
  logic [PAT_W-2:0] sreg_q;
  logic [PAT_W-1:0] pat_sh_q;
`ifdef STR_DET_MASK_EN
  logic [PAT_W-1:0] mask_sh_q;
`endif
  logic             mode_sh_q;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] live_q;
  logic [CNT_W-1:0] result_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             match_q;
  logic             frame_done_q;
  logic             busy_gap_q;

  logic [PAT_W-1:0] window_s;
  logic             cmp_hit_s;
  logic             hit_s;
  logic             last_bit_s;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] fill_d;

  str_det_cmp #(.W(PAT_W)) u_cmp (
    .window_i  (window_s),
    .pattern_i (pat_sh_q),
`ifdef STR_DET_MASK_EN
    .mask_i    (mask_sh_q),
`endif
    .hit_o     (cmp_hit_s)
  );

  // Next window, qualified hit, and next count / fill for an accepted bit.
  // The first bit of a frame compares against stale shadows, but it can never
  // hit because fill is still 0 there.
  always_comb begin
    window_s   = {sreg_q, bus.bit_in};
    hit_s      = cmp_hit_s && (fill_q >= FILL_THR);
    last_bit_s = (bit_cnt_q == LAST_BIT);
    if (hit_s) begin
      count_d = CNT_W'(sat_inc(32'(live_q), CNT_W));
    end else begin
      count_d = live_q;
    end
    if (hit_s && mode_sh_q) begin
      fill_d = {CNT_W{1'b0}};
    end else if (fill_q == FILL_MAX) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + CNT_W'(1);
    end
  end

  // Frame sequencer with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      sreg_q       <= '0;
      pat_sh_q     <= '0;
`ifdef STR_DET_MASK_EN
      mask_sh_q    <= '0;
`endif
      mode_sh_q    <= 1'b0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      live_q       <= '0;
      result_q     <= '0;
      gap_cnt_q    <= '0;
      match_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_gap_q   <= 1'b0;
    end else if (bus.clear) begin
      state_q      <= RUN;
      sreg_q       <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      live_q       <= '0;
      gap_cnt_q    <= '0;
      match_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_gap_q   <= 1'b0;
    end else begin
      match_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.bit_valid) begin
            if (bit_cnt_q == '0) begin
              pat_sh_q  <= bus.pattern;
              mode_sh_q <= bus.mode;
`ifdef STR_DET_MASK_EN
              mask_sh_q <= bus.pat_mask;
`endif
            end
            match_q <= hit_s;
            if (last_bit_s) begin
              result_q     <= count_d;
              frame_done_q <= 1'b1;
              if (GAP_LEN == 0) begin
                // No flush: start the next frame clean right away.
                sreg_q    <= '0;
                fill_q    <= '0;
                bit_cnt_q <= '0;
                live_q    <= '0;
              end else begin
                sreg_q     <= window_s[PAT_W-2:0];
                live_q     <= count_d;
                state_q    <= GAP;
                gap_cnt_q  <= '0;
                busy_gap_q <= 1'b1;
              end
            end else begin
              sreg_q    <= window_s[PAT_W-2:0];
              live_q    <= count_d;
              fill_q    <= fill_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q    <= RUN;
            busy_gap_q <= 1'b0;
            gap_cnt_q  <= '0;
            sreg_q     <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            live_q     <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q    <= RUN;
          busy_gap_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.match      = match_q;
  assign bus.live_count = live_q;
  assign bus.result     = result_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy_gap   = busy_gap_q;

endmodule

// File: tb/tb_str_det_frame.sv
// Directed self-checking bench for str_det_frame: one DUT with a 4-cycle
// flush and one with no flush (back-to-back frames).
module tb_str_det_frame;

  localparam int PW = 4;
  localparam int FL = 20;
  localparam int CW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  str_det_frame_if #(.PAT_W(PW), .CNT_W(CW)) bus  ();
  str_det_frame_if #(.PAT_W(PW), .CNT_W(CW)) bus0 ();

  str_det_frame #(.PAT_W(PW), .FRAME_LEN(FL), .GAP_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  str_det_frame #(.PAT_W(PW), .FRAME_LEN(FL), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.pattern = 4'b1011;  bus.mode = 1'b0;  bus.clear = 1'b0;
    bus.bit_in = 1'b0;      bus.bit_valid = 1'b0;
    bus0.pattern = 4'b1011; bus0.mode = 1'b0; bus0.clear = 1'b0;
    bus0.bit_in = 1'b0;     bus0.bit_valid = 1'b0;
`ifdef STR_DET_MASK_EN
    bus.pat_mask = 4'b1111;
    bus0.pat_mask = 4'b1111;
`endif
  endtask

  task automatic test_reset();
    tick(); tick();
    if (bus.match !== 1'b0) begin $display("FAIL rst_match got %b want 0", bus.match); n_err++; end
    n_cmp++;
    if (bus.live_count !== 5'd0) begin $display("FAIL rst_live got %0d want 0", bus.live_count); n_err++; end
    n_cmp++;
    if (bus.result !== 5'd0) begin $display("FAIL rst_result got %0d want 0", bus.result); n_err++; end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin $display("FAIL rst_done got %b want 0", bus.frame_done); n_err++; end
    n_cmp++;
    if (bus.busy_gap !== 1'b0) begin $display("FAIL rst_busy got %b want 0", bus.busy_gap); n_err++; end
    n_cmp++;
    if (bus0.result !== 5'd0) begin $display("FAIL rst_result0 got %0d want 0", bus0.result); n_err++; end
    n_cmp++;
    rst_n = 1'b1;
    tick();
  endtask

  // Stream 1011011 + 13 zeros in both modes; pattern/mode changed mid-frame must be ignored.
  task automatic test_modes();
    logic [19:0] s;
    logic [19:0] exp_m;
    logic [4:0]  exp_r;
    int done_cnt, busy_cnt;
    s = 20'b1011011_0000000000000;
    for (int m = 0; m < 2; m++) begin
      exp_m = (m == 0) ? 20'b0001001_0000000000000 : 20'b0001000_0000000000000;
      exp_r = (m == 0) ? 5'd2 : 5'd1;
      bus.pattern = 4'b1011; bus.mode = m[0];
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        bus.bit_in = s[19-i]; bus.bit_valid = 1'b1;
        tick();
        if (i == 2) begin bus.pattern = 4'b0000; bus.mode = ~m[0]; end
        if (bus.match !== exp_m[19-i]) begin
          $display("FAIL modes_match m%0d bit%0d got %b want %b", m, i + 1, bus.match, exp_m[19-i]); n_err++;
        end
        n_cmp++;
        if (bus.frame_done === 1'b1) done_cnt++;
      end
      bus.bit_valid = 1'b0;
      if (bus.result !== exp_r) begin $display("FAIL modes_result m%0d got %0d want %0d", m, bus.result, exp_r); n_err++; end
      n_cmp++;
      if (bus.live_count !== exp_r) begin $display("FAIL modes_live_gap m%0d got %0d want %0d", m, bus.live_count, exp_r); n_err++; end
      n_cmp++;
      busy_cnt = (bus.busy_gap === 1'b1) ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.busy_gap === 1'b1) busy_cnt++;
        else break;
      end
      if (busy_cnt != 4) begin $display("FAIL modes_busy m%0d got %0d want 4", m, busy_cnt); n_err++; end
      n_cmp++;
      if (done_cnt != 1) begin $display("FAIL modes_done m%0d got %0d want 1", m, done_cnt); n_err++; end
      n_cmp++;
      if (bus.live_count !== 5'd0) begin $display("FAIL modes_live_exit m%0d got %0d want 0", m, bus.live_count); n_err++; end
      n_cmp++;
      bus.pattern = 4'b1011; bus.mode = 1'b0;
    end
  endtask

  // Twenty ones against 1111: 17 overlapping, 5 non-overlapping.
  task automatic test_all_ones();
    int mcnt, busy_cnt;
    logic [4:0] exp_r;
    for (int m = 0; m < 2; m++) begin
      exp_r = (m == 0) ? 5'd17 : 5'd5;
      bus.pattern = 4'b1111; bus.mode = m[0];
      mcnt = 0;
      for (int i = 0; i < 20; i++) begin
        bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
        tick();
        if (bus.match === 1'b1) mcnt++;
      end
      bus.bit_valid = 1'b0;
      if (mcnt != int'(exp_r)) begin $display("FAIL ones_pulses m%0d got %0d want %0d", m, mcnt, exp_r); n_err++; end
      n_cmp++;
      if (bus.result !== exp_r) begin $display("FAIL ones_result m%0d got %0d want %0d", m, bus.result, exp_r); n_err++; end
      n_cmp++;
      busy_cnt = 1;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (bus.busy_gap === 1'b1) busy_cnt++;
        else break;
      end
      if (busy_cnt != 4) begin $display("FAIL ones_busy m%0d got %0d want 4", m, busy_cnt); n_err++; end
      n_cmp++;
      if (bus.live_count !== 5'd0) begin $display("FAIL ones_live_exit m%0d got %0d want 0", m, bus.live_count); n_err++; end
      n_cmp++;
    end
    bus.pattern = 4'b1011; bus.mode = 1'b0;
  endtask

  // Abort after bit 10 of a 2-match frame; previous result (5) must survive.
  task automatic test_clear();
    logic [19:0] s;
    logic [19:0] exp_m;
    int busy_cnt;
    s     = 20'b1011011_0000000000000;
    exp_m = 20'b0001001_0000000000000;
    for (int i = 0; i < 10; i++) begin
      bus.bit_in = s[19-i]; bus.bit_valid = 1'b1;
      tick();
    end
    if (bus.live_count !== 5'd2) begin $display("FAIL clr_live_before got %0d want 2", bus.live_count); n_err++; end
    n_cmp++;
    bus.clear = 1'b1; bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
    tick();
    bus.clear = 1'b0; bus.bit_valid = 1'b0;
    if (bus.live_count !== 5'd0) begin $display("FAIL clr_live got %0d want 0", bus.live_count); n_err++; end
    n_cmp++;
    if (bus.result !== 5'd5) begin $display("FAIL clr_result got %0d want 5", bus.result); n_err++; end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin $display("FAIL clr_done got %b want 0", bus.frame_done); n_err++; end
    n_cmp++;
    for (int i = 0; i < 20; i++) begin
      bus.bit_in = s[19-i]; bus.bit_valid = 1'b1;
      tick();
      if (bus.match !== exp_m[19-i]) begin
        $display("FAIL clr_match bit%0d got %b want %b", i + 1, bus.match, exp_m[19-i]); n_err++;
      end
      n_cmp++;
      if (bus.frame_done !== (i == 19)) begin
        $display("FAIL clr_done_pos bit%0d got %b want %b", i + 1, bus.frame_done, (i == 19)); n_err++;
      end
      n_cmp++;
    end
    bus.bit_valid = 1'b0;
    if (bus.result !== 5'd2) begin $display("FAIL clr_next_result got %0d want 2", bus.result); n_err++; end
    n_cmp++;
    busy_cnt = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.busy_gap === 1'b1) busy_cnt++;
      else break;
    end
    if (busy_cnt != 4) begin $display("FAIL clr_busy got %0d want 4", busy_cnt); n_err++; end
    n_cmp++;
  endtask

  // Same stream as test_modes (mode 0) with idle cycles in between; bit_in toggles while idle.
  task automatic test_idle_gaps();
    logic [19:0] s;
    logic [19:0] exp_m;
    int done_cnt, busy_cnt;
    s     = 20'b1011011_0000000000000;
    exp_m = 20'b0001001_0000000000000;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < (i % 3); j++) begin
        bus.bit_in = ~bus.bit_in; bus.bit_valid = 1'b0;
        tick();
        if (bus.match !== 1'b0) begin $display("FAIL idle_match_quiet bit%0d got %b want 0", i + 1, bus.match); n_err++; end
        n_cmp++;
        if (bus.frame_done === 1'b1) done_cnt++;
      end
      bus.bit_in = s[19-i]; bus.bit_valid = 1'b1;
      tick();
      if (bus.match !== exp_m[19-i]) begin
        $display("FAIL idle_match bit%0d got %b want %b", i + 1, bus.match, exp_m[19-i]); n_err++;
      end
      n_cmp++;
      if (bus.frame_done === 1'b1) done_cnt++;
    end
    bus.bit_valid = 1'b0;
    if (bus.result !== 5'd2) begin $display("FAIL idle_result got %0d want 2", bus.result); n_err++; end
    n_cmp++;
    busy_cnt = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.busy_gap === 1'b1) busy_cnt++;
      else break;
    end
    if (done_cnt != 1) begin $display("FAIL idle_done got %0d want 1", done_cnt); n_err++; end
    n_cmp++;
    if (busy_cnt != 4) begin $display("FAIL idle_busy got %0d want 4", busy_cnt); n_err++; end
    n_cmp++;
  endtask

  // No-flush DUT: continuous 40 bits; 1011 straddling the boundary must not count.
  task automatic test_back_to_back();
    logic [39:0] s;
    logic [39:0] exp_m;
    s     = {20'b1011_0000000000000_101, 20'b1011011_0000000000000};
    exp_m = {20'b0001_0000000000000_000, 20'b0001001_0000000000000};
    bus0.pattern = 4'b1011; bus0.mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus0.bit_in = s[39-i]; bus0.bit_valid = 1'b1;
      tick();
      if (bus0.match !== exp_m[39-i]) begin
        $display("FAIL b2b_match bit%0d got %b want %b", i + 1, bus0.match, exp_m[39-i]); n_err++;
      end
      n_cmp++;
      if (bus0.frame_done !== (i == 19 || i == 39)) begin
        $display("FAIL b2b_done bit%0d got %b want %b", i + 1, bus0.frame_done, (i == 19 || i == 39)); n_err++;
      end
      n_cmp++;
      if (bus0.busy_gap !== 1'b0) begin $display("FAIL b2b_busy bit%0d got %b want 0", i + 1, bus0.busy_gap); n_err++; end
      n_cmp++;
      if (i == 19) begin
        if (bus0.result !== 5'd1) begin $display("FAIL b2b_result1 got %0d want 1", bus0.result); n_err++; end
        n_cmp++;
        if (bus0.live_count !== 5'd0) begin $display("FAIL b2b_live_clean got %0d want 0", bus0.live_count); n_err++; end
        n_cmp++;
      end
    end
    bus0.bit_valid = 1'b0;
    if (bus0.result !== 5'd2) begin $display("FAIL b2b_result2 got %0d want 2", bus0.result); n_err++; end
    n_cmp++;
  endtask

  // Asynchronous reset in the middle of a frame wipes everything, result included.
  task automatic test_reset_midframe();
    logic [4:0] s;
    s = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      bus.bit_in = s[4-i]; bus.bit_valid = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    if (bus.live_count !== 5'd1) begin $display("FAIL mid_live_before got %0d want 1", bus.live_count); n_err++; end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if (bus.live_count !== 5'd0) begin $display("FAIL mid_rst_live got %0d want 0", bus.live_count); n_err++; end
    n_cmp++;
    if (bus.result !== 5'd0) begin $display("FAIL mid_rst_result got %0d want 0", bus.result); n_err++; end
    n_cmp++;
    if (bus0.result !== 5'd0) begin $display("FAIL mid_rst_result0 got %0d want 0", bus0.result); n_err++; end
    n_cmp++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_modes();
    test_all_ones();
    test_clear();
    test_idle_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
